ser2par_align: RTL and testbench
================================

Name: ser2par_align

Overview:
- Parametrised serial-to-parallel deserializer with comma-based word alignment, lock tracking and selectable input polarity inversion.
- Next generation of the fixed 10-bit ser2par in the SERDES path. Recovers word boundaries from a known comma symbol instead of relying on a reset-relative bit count.
- Sits after the serial line, on the receive clock; feeds parallel words plus valid and lock status to the decoder.

Parameters:
- WIDTH, 10, parallel word width in bits (≥4).
- COMMA, 10'b0011111010, alignment symbol (K28.5 RD-); its bitwise complement is also accepted as a comma.
- LOCK_COUNT, 3, consecutive boundary-aligned commas required to declare lock (≥1).
- LOSS_COUNT, 4, consecutive off-boundary commas that drop lock (≥1).

Ports:
- clk  input  1  single clock, rising edge, one serial bit per cycle
- reset  input  1  asynchronous, active-high reset
- ser_in  input  1  serial data, MSB of each word first
- neg  input  1  1 = invert ser_in before use
- par_out  output  WIDTH  last complete aligned word
- par_valid  output  1  one-cycle pulse when par_out updates (LOCKED only)
- locked  output  1  high in LOCKED state
- comma_det  output  1  one-cycle pulse when an aligned word equals a comma (LOCKED only)

Behaviour:
- Reset (async, any time, including mid-word): sr, par_out, bit counter, good_cnt, bad_cnt, fill counter = 0; state = HUNT; par_valid, locked, comma_det = 0.
- Each edge: b = ser_in ^ neg; nsr = {sr[WIDTH-2:0], b}; sr <= nsr.
- Fill counter saturates at WIDTH. Comma matching is ignored until WIDTH bits have been shifted in since reset.
- is_comma = (nsr == COMMA) || (nsr == ~COMMA).
- boundary = (bit counter == WIDTH-1). Bit counter increments modulo WIDTH.
- Realign: bit counter <= 0 on this edge, so the next bit is bit 0 of a new word.
- HUNT:
  - If is_comma: realign, set good_cnt = 1, and go to SYNC. If LOCK_COUNT == 1, go directly to LOCKED.
  - Otherwise remain in HUNT.
- SYNC:
  - boundary && is_comma: good_cnt++. Reaching LOCK_COUNT goes to LOCKED on that edge.
  - boundary && !is_comma: no change.
  - !boundary && is_comma: realign, set good_cnt = 1, stay in SYNC.
- LOCKED:
  - On every boundary: par_out <= nsr; par_valid = 1 for one cycle.
  - If that word is a comma: comma_det = 1 for one cycle and bad_cnt = 0.
  - !boundary && is_comma: bad_cnt++. Reaching LOSS_COUNT goes to HUNT on that edge: locked = 0, good_cnt = bad_cnt = 0, and no realign on that edge.
  - The word completing on the edge that enters LOCKED is itself emitted (par_valid = 1, comma_det = 1).
- Latency: par_out/par_valid are visible in the cycle after the edge that samples the word's last bit.
- All outputs are registered. locked = (state == LOCKED). par_out holds its value between pulses and across lock loss.
- neg changes take effect from the next sampled bit. They do not by themselves cause realignment.
- Simultaneous boundary and comma in LOCKED counts as good, never bad.

Test Plan:
- Reset mid-operation: assert reset while LOCKED mid-word → par_out = 0, locked = 0, par_valid = 0 immediately (async). After release, the stream needs LOCK_COUNT commas again.
- Lock acquisition: 3 junk bits, then COMMA ×3 back-to-back, neg = 0 → locked rises in the cycle after the 33rd bit's edge. par_valid and comma_det pulse once, with par_out = 10'b0011111010.
- Data after lock: send 10'h123, then 10'h2A5 → par_valid pulses exactly 10 cycles apart with par_out = 10'h123, then 10'h2A5. comma_det stays 0.
- Polarity and disparity: drive the complemented stream (~COMMA ×3, then ~10'h123) with neg = 1 → identical par_out/locked sequence to the lock-acquisition and data scenarios. Then ~COMMA ×3 with neg = 0 also locks.
- Bit slip: after lock, insert one extra bit, then COMMA ×4 → bad_cnt reaches 4 and locked falls after the 4th misaligned comma. Further COMMA ×3 at the new alignment relock.
- Realign in SYNC: 1 comma, slip 2 bits, 3 commas → no lock until the 3rd comma at the new alignment. No par_valid is emitted before lock.

Source files
------------

// File: rtl/ser2par_align.sv
// rtl/ser2par_align.sv - comma-aligned serial-to-parallel deserializer with lock tracking
//
// Shifts one serial bit per clock into a word register, hunts for the comma
// symbol (or its complement) to find word boundaries, and declares lock after
// LOCK_COUNT consecutive commas on the same boundary. Once locked, every
// completed word is presented on par_out with a one-cycle par_valid pulse;
// LOSS_COUNT consecutive commas seen off the boundary drop lock again.
//
// Ports:
//   clk        receive clock, one serial bit sampled per rising edge
//   reset      asynchronous active-high reset
//   ser_in     serial data, MSB of each word first
//   neg        1 = invert ser_in before use
//   par_out    last complete aligned word (held between pulses)
//   par_valid  one-cycle pulse when par_out updates (locked only)
//   locked     high while in the LOCKED state
//   comma_det  one-cycle pulse when an aligned word is a comma (locked only)

module ser2par_align #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] COMMA      = 10'b0011111010,
  parameter int               LOCK_COUNT = 3,
  parameter int               LOSS_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             neg,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             locked,
  output logic             comma_det
);

  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_n;

  // Only the newest WIDTH-1 bits need to be kept: the incoming bit completes
  // the word combinationally, so the oldest bit would never be read.
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [FW-1:0]    fill_cnt, fill_cnt_n;
  logic [GW-1:0]    good_cnt, good_cnt_n;
  logic [BW-1:0]    bad_cnt, bad_cnt_n;

  logic             b;
  logic [WIDTH-1:0] nsr;
  logic             fill_done;
  logic             is_comma;
  logic             boundary;
  logic             emit;
  logic             comma_hit;

  always_comb begin
    b          = ser_in ^ neg;
    nsr        = {sr, b};
    // After this edge fill_cnt+1 bits are in the word; match only once full.
    fill_done  = (fill_cnt >= FILL_LAST);
    is_comma   = fill_done && ((nsr == COMMA) || (nsr == ~COMMA));
    boundary   = (bit_cnt == BIT_LAST);
    fill_cnt_n = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + FW'(1);

    state_n    = state;
    bit_cnt_n  = boundary ? '0 : bit_cnt + CW'(1);
    good_cnt_n = good_cnt;
    bad_cnt_n  = bad_cnt;
    emit       = 1'b0;
    comma_hit  = 1'b0;

    unique case (state)
      HUNT: begin
        if (is_comma) begin
          bit_cnt_n  = '0;
          good_cnt_n = GW'(1);
          if (LOCK_COUNT == 1) begin
            // The comma that completes lock is itself emitted.
            state_n   = LOCKED;
            emit      = 1'b1;
            comma_hit = 1'b1;
          end else begin
            state_n = SYNC;
          end
        end
      end

      SYNC: begin
        if (boundary && is_comma) begin
          good_cnt_n = good_cnt + GW'(1);
          if (good_cnt == LOCK_LAST) begin
            state_n   = LOCKED;
            bad_cnt_n = '0;
            emit      = 1'b1;
            comma_hit = 1'b1;
          end
        end else if (!boundary && is_comma) begin
          bit_cnt_n  = '0;
          good_cnt_n = GW'(1);
        end
      end

      LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (is_comma) begin
            comma_hit = 1'b1;
            bad_cnt_n = '0;
          end
        end else if (is_comma) begin
          if (bad_cnt == LOSS_LAST) begin
            // Drop lock without realigning; HUNT will realign on the next comma.
            state_n    = HUNT;
            good_cnt_n = '0;
            bad_cnt_n  = '0;
          end else begin
            bad_cnt_n = bad_cnt + BW'(1);
          end
        end
      end

      default: begin
        state_n = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
      comma_det <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sr        <= nsr[WIDTH-2:0];
      bit_cnt   <= bit_cnt_n;
      fill_cnt  <= fill_cnt_n;
      good_cnt  <= good_cnt_n;
      bad_cnt   <= bad_cnt_n;
      par_valid <= emit;
      comma_det <= comma_hit;
      locked    <= (state_n == LOCKED);
      if (emit) begin
        par_out <= nsr;
      end
    end
  end

endmodule

// File: tb/tb_ser2par_align.sv
// tb/tb_ser2par_align.sv - directed table-driven bench for ser2par_align

module tb_ser2par_align;

  localparam int         W = 10;
  localparam logic [9:0] C = 10'b0011111010;
  localparam logic [9:0] NC = 10'b1100000101;
  localparam logic [9:0] SLIPW = 10'b0001111101;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ser_in = 1'b0;
  logic         neg = 1'b0;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         locked;
  logic         comma_det;

  int checks = 0;
  int errors = 0;
  int vcnt, vidx, ccnt;

  ser2par_align #(
    .WIDTH(W), .COMMA(C), .LOCK_COUNT(3), .LOSS_COUNT(4)
  ) dut (
    .clk(clk), .reset(reset), .ser_in(ser_in), .neg(neg),
    .par_out(par_out), .par_valid(par_valid), .locked(locked), .comma_det(comma_det)
  );

  always #5 clk = ~clk;

  // op 0 = send nbits of data (MSB first), op 1 = async reset away from the edge
  typedef struct {
    int         op;
    logic [9:0] data;
    int         nbits;
    logic       n;
    logic       exp_locked;
    int         exp_vcnt;
    int         exp_vidx;
    logic [9:0] exp_par;
    int         exp_ccnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int op, input logic [9:0] d, input int nb, input logic n,
                              input logic l, input int vc, input int vi,
                              input logic [9:0] p, input int cc);
    vec_t v;
    v.op = op; v.data = d; v.nbits = nb; v.n = n; v.exp_locked = l;
    v.exp_vcnt = vc; v.exp_vidx = vi; v.exp_par = p; v.exp_ccnt = cc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [9:0] data, input int nbits, input logic n);
    vcnt = 0; vidx = -1; ccnt = 0;
    for (int i = 0; i < nbits; i++) begin
      ser_in = data[nbits-1-i];
      neg    = n;
      @(posedge clk);
      #1;
      if (par_valid) begin
        vcnt++;
        vidx = i;
      end
      if (comma_det) ccnt++;
    end
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, " par_out"}, int'(par_out), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " par_valid"}, int'(par_valid), 0);
    chk({tag, " comma_det"}, int'(comma_det), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Lock acquisition, data, bit slip, relock, mid-word reset.
    tbl.push_back(mk(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, 10'h000, 3, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 9, C, 1));
    tbl.push_back(mk(0, 10'h123, 10, 0, 1, 1, 9, 10'h123, 0));
    tbl.push_back(mk(0, 10'h2A5, 10, 0, 1, 1, 9, 10'h2A5, 0));
    tbl.push_back(mk(0, 10'h000, 1, 0, 1, 0, 0, 10'h2A5, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 8, SLIPW, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 8, SLIPW, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 8, SLIPW, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 1, 8, SLIPW, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, SLIPW, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, SLIPW, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 9, C, 1));
    tbl.push_back(mk(0, 10'h009, 5, 0, 1, 0, 0, C, 0));
    tbl.push_back(mk(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, 10'h000, 3, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 9, C, 1));
    // Complemented stream with neg = 1 looks identical after inversion.
    tbl.push_back(mk(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, 10'h007, 3, 1, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, NC, 10, 1, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, NC, 10, 1, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, NC, 10, 1, 1, 1, 9, C, 1));
    tbl.push_back(mk(0, ~10'h123, 10, 1, 1, 1, 9, 10'h123, 0));
    // Opposite-disparity comma with neg = 0 also locks.
    tbl.push_back(mk(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, 10'h000, 3, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, NC, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, NC, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, NC, 10, 0, 1, 1, 9, NC, 1));
    // Realign while in SYNC: one comma, 2-bit slip, then three commas.
    tbl.push_back(mk(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, 10'h000, 3, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, 10'h000, 2, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 0, 0, 0, 10'h000, 0));
    tbl.push_back(mk(0, C, 10, 0, 1, 1, 9, C, 1));

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].op == 1) begin
        do_reset($sformatf("v%0d reset", k));
      end else begin
        send(tbl[k].data, tbl[k].nbits, tbl[k].n);
        chk($sformatf("v%0d locked", k), int'(locked), int'(tbl[k].exp_locked));
        chk($sformatf("v%0d valid_count", k), vcnt, tbl[k].exp_vcnt);
        if (tbl[k].exp_vcnt > 0)
          chk($sformatf("v%0d valid_bit_index", k), vidx, tbl[k].exp_vidx);
        chk($sformatf("v%0d par_out", k), int'(par_out), int'(tbl[k].exp_par));
        chk($sformatf("v%0d comma_count", k), ccnt, tbl[k].exp_ccnt);
      end
    end

    // neg flipped mid-word: affects only later bits and does not realign.
    do_reset("negflip reset");
    send(10'h000, 3, 0);
    for (int k = 0; k < 3; k++) send(C, 10, 0);
    chk("negflip lock", int'(locked), 1);
    send(10'h009, 5, 0);
    chk("negflip first half valid", vcnt, 0);
    send(10'h003, 5, 1);
    chk("negflip valid_count", vcnt, 1);
    chk("negflip valid_bit_index", vidx, 4);
    chk("negflip par_out", int'(par_out), 10'h13C);
    chk("negflip still locked", int'(locked), 1);
    send(10'h2A5, 10, 0);
    chk("negflip next valid_bit_index", vidx, 9);
    chk("negflip next par_out", int'(par_out), 10'h2A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
